serial_subtractor: RTL and testbench

- Bit-serial two's-complement subtractor; computes diff = a - b, one bit per clock, LSB first.
- Inverse operation to the ripple-carry adder datapath, built around a single-bit full-subtractor cell (borrow chain instead of carry chain).
- Used where area matters more than latency; pairs with the adder blocks in the arithmetic unit for add/sub comparisons.

---
 rtl/serial_sub_pkg.sv | 18 +
 rtl/single_bit_full_subtractor.sv | 19 +
 rtl/serial_subtractor.sv | 138 +++++++++++++
 tb/tb_serial_subtractor.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
`default_nettype none
// ============================================================================
// Module   : serial_sub_pkg
// Purpose  : Shared state encoding and defaults for the bit-serial subtractor.
// Revision : 1.0 - initial release
// ============================================================================
package serial_sub_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_DONE = 2'd2;

    localparam int DEFAULT_WIDTH = 8;

endpackage : serial_sub_pkg
`default_nettype wire

// File: rtl/single_bit_full_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : single_bit_full_subtractor
// Purpose  : Combinational one-bit full subtractor (a - b - bw_in).
// Revision : 1.0 - initial release
// ============================================================================
module single_bit_full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bw_in,
    output logic diff,
    output logic bw_out
);

    assign diff   = a ^ b ^ bw_in;
    assign bw_out = (~a & b) | (~(a ^ b) & bw_in);

endmodule : single_bit_full_subtractor
`default_nettype wire

// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : serial_subtractor
// Purpose  : Bit-serial two's-complement subtractor, diff = a - b, LSB first.
//            Optional signed-overflow output enabled by SERIAL_SUB_OVF_EN.
// Revision : 1.0 - initial release
// ============================================================================
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             done,
    output logic             busy
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             overflow
`endif
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t             r_state;
    state_t             w_state_next;
    logic [WIDTH-1:0]   r_a_sh;
    logic [WIDTH-1:0]   r_b_sh;
    logic [WIDTH-1:0]   r_diff;
    logic [WIDTH-1:0]   w_diff_next;
    logic [CNT_W-1:0]   r_count;
    logic               r_borrow;
    logic               r_borrow_out;
    logic               w_bit;
    logic               w_bw;
    logic               w_last;
    logic               w_accept;

    assign w_last   = (r_count == CNT_W'(WIDTH - 1));
    assign w_accept = (r_state == ST_IDLE) && start;

    single_bit_full_subtractor u_fs (
        .a      (r_a_sh[0]),
        .b      (r_b_sh[0]),
        .bw_in  (r_borrow),
        .diff   (w_bit),
        .bw_out (w_bw)
    );

    // Result bits enter at the MSB and move toward the LSB as the word fills.
    generate
        if (WIDTH == 1) begin : g_w1
            assign w_diff_next = w_bit;
        end else begin : g_wn
            assign w_diff_next = {w_bit, r_diff[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (start)  w_state_next = ST_RUN;
            ST_RUN:  if (w_last) w_state_next = ST_DONE;
            ST_DONE: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        done = (r_state == ST_DONE);
        busy = (r_state != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_sh       <= '0;
            r_b_sh       <= '0;
            r_diff       <= '0;
            r_count      <= '0;
            r_borrow     <= 1'b0;
            r_borrow_out <= 1'b0;
        end else if (w_accept) begin
            r_a_sh   <= a;
            r_b_sh   <= b;
            r_count  <= '0;
            r_borrow <= 1'b0;
        end else if (r_state == ST_RUN) begin
            r_diff   <= w_diff_next;
            r_a_sh   <= r_a_sh >> 1;
            r_b_sh   <= r_b_sh >> 1;
            r_count  <= r_count + 1'b1;
            r_borrow <= w_bw;
            if (w_last) begin
                r_borrow_out <= w_bw;
            end
        end
    end

    assign diff       = r_diff;
    assign borrow_out = r_borrow_out;

`ifdef SERIAL_SUB_OVF_EN
    logic r_a_msb;
    logic r_b_msb;
    logic r_overflow;

    // On the last RUN edge w_bit is the final result MSB.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_msb    <= 1'b0;
            r_b_msb    <= 1'b0;
            r_overflow <= 1'b0;
        end else if (w_accept) begin
            r_a_msb <= a[WIDTH-1];
            r_b_msb <= b[WIDTH-1];
        end else if ((r_state == ST_RUN) && w_last) begin
            r_overflow <= (r_a_msb != r_b_msb) && (w_bit != r_a_msb);
        end
    end

    assign overflow = r_overflow;
`endif

endmodule : serial_subtractor
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_subtractor
// Purpose  : Scoreboard bench for serial_subtractor (WIDTH=8 and WIDTH=1).
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a, b, diff;
    logic         borrow_out, done, busy;
    logic         start1;
    logic [0:0]   a1, b1, diff1;
    logic         borrow1, done1, busy1;
`ifdef SERIAL_SUB_OVF_EN
    logic         overflow, overflow1;
`endif

    serial_subtractor #(.WIDTH(W)) u_dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .diff(diff), .borrow_out(borrow_out), .done(done), .busy(busy)
`ifdef SERIAL_SUB_OVF_EN
        , .overflow(overflow)
`endif
    );

    serial_subtractor #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1),
        .diff(diff1), .borrow_out(borrow1), .done(done1), .busy(busy1)
`ifdef SERIAL_SUB_OVF_EN
        , .overflow(overflow1)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [W-1:0] d;
        logic         bo;
        logic         ov;
        int           cyc;
    } exp_t;

    exp_t sbq[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    // Reference: plain integer arithmetic on the operand values.
    function automatic exp_t model(input int x, input int y, input int wid, input int acc_cyc);
        exp_t e;
        int   m, sx, sy, sd;
        m     = 1 << wid;
        e.d   = W'((x - y + m) % m);
        e.bo  = (x < y);
        sx    = (x >= m / 2) ? x - m : x;
        sy    = (y >= m / 2) ? y - m : y;
        sd    = sx - sy;
        e.ov  = (sd > m / 2 - 1) || (sd < -(m / 2));
        e.cyc = acc_cyc + wid;
        return e;
    endfunction

    // Monitor: compare each completion against the oldest expectation.
    bit prev_done = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (done) begin
            chk("done_single_cycle", prev_done, 0);
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got done=1 expected no pending op (t=%0t)", $time);
            end else begin
                e = sbq.pop_front();
                chk("diff", diff, e.d);
                chk("borrow_out", borrow_out, e.bo);
                chk("done_latency_cycle", cyc, e.cyc);
`ifdef SERIAL_SUB_OVF_EN
                chk("overflow", overflow, e.ov);
`endif
            end
        end
        prev_done = done;
    end

    task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input bit push);
        @(negedge clk);
        a     = x;
        b     = y;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (push) sbq.push_back(model(int'(x), int'(y), W, cyc));
    endtask

    task automatic wait_done();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < W + 4; i++) begin
            @(negedge clk);
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        chk("done_seen_in_time", ok, 1);
    endtask

    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y);
        issue(x, y, 1'b1);
        wait_done();
        @(negedge clk);
        chk("busy_low_after_done", busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        exp_t e;
        rst    = 1'b1;
        start  = 1'b0;
        start1 = 1'b0;
        a      = '0;
        b      = '0;
        a1     = '0;
        b1     = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_diff", diff, 0);
        chk("reset_borrow", borrow_out, 0);
        chk("reset_done", done, 0);
        chk("reset_busy", busy, 0);
`ifdef SERIAL_SUB_OVF_EN
        chk("reset_overflow", overflow, 0);
`endif
        rst = 1'b0;

        // Directed operands including signed-overflow corners.
        run_op(8'h50, 8'h20);
        run_op(8'h20, 8'h50);
        run_op(8'hFF, 8'hFF);
        run_op(8'h80, 8'h01);
        run_op(8'h05, 8'h03);
        run_op(8'h00, 8'h00);
        run_op(8'h7F, 8'h80);
        run_op(8'h00, 8'hFF);

        // A new start three cycles into RUN must be ignored.
        issue(8'h50, 8'h20, 1'b1);
        repeat (3) @(negedge clk);
        a     = 8'hAA;
        b     = 8'h11;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        @(negedge clk);
        chk("busy_low_after_ignored_start", busy, 0);

        // Start held during the done cycle is ignored; result holds in IDLE.
        issue(8'h3C, 8'h4D, 1'b1);
        e = model(8'h3C, 8'h4D, W, 0);
        wait_done();
        a     = 8'h01;
        b     = 8'h02;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start_in_done", busy, 0);
        repeat (3) @(negedge clk);
        chk("busy_stays_idle", busy, 0);
        chk("diff_held_in_idle", diff, e.d);
        chk("borrow_held_in_idle", borrow_out, e.bo);

        // Reset at the fourth RUN edge aborts with no completion.
        issue(8'h33, 8'h11, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrun_rst_diff", diff, 0);
        chk("midrun_rst_borrow", borrow_out, 0);
        chk("midrun_rst_busy", busy, 0);
        chk("midrun_rst_done", done, 0);
        repeat (W + 2) @(negedge clk);
        chk("no_done_after_abort", busy, 0);
        run_op(8'h50, 8'h20);

        for (int i = 0; i < 24; i++) begin
            run_op(W'($urandom), W'($urandom));
        end

        // WIDTH=1 instance: all operand pairs.
        for (int i = 0; i < 4; i++) begin
            e = model(i >> 1, i & 1, 1, 0);
            @(negedge clk);
            a1     = 1'((i >> 1) & 1);
            b1     = 1'(i & 1);
            start1 = 1'b1;
            @(posedge clk);
            #1;
            start1 = 1'b0;
            @(negedge clk);
            chk("w1_busy_run", busy1, 1);
            chk("w1_done_early", done1, 0);
            @(negedge clk);
            chk("w1_done", done1, 1);
            chk("w1_diff", diff1, e.d[0]);
            chk("w1_borrow", borrow1, e.bo);
`ifdef SERIAL_SUB_OVF_EN
            chk("w1_overflow", overflow1, e.ov);
`endif
            @(negedge clk);
            chk("w1_busy_idle", busy1, 0);
        end

        repeat (2) @(negedge clk);
        chk("scoreboard_empty", sbq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_serial_subtractor
`default_nettype wire
